// File: rtl/logic_key_loader.sv
// ---------------------------------------------------------------------------
// logic_key_loader
//
// Serial key-delivery unit for XOR/MUX-locked combinational cores. A frame of
// NP+NX+1 bits arrives over a valid/ready handshake, first bit first:
//   bits 0..NP-1        -> MUX-select key p   (key_p[0] = p1)
//   bits NP..NP+NX-1    -> XOR key X          (key_x[0] = X_1)
//   last bit            -> even parity over the preceding NP+NX bits
// Bits collect in a shadow register. The key buses are updated atomically
// one cycle after the last bit, and only when the frame's parity is clean,
// so the locked core never sees a partially loaded key.
//
// Optional lockout, enabled by defining KEY_LOADER_LOCKOUT_EN: after MAX_FAIL
// consecutive failed frames (bad parity or timeout) the unit enters a LOCKED
// state that only rst leaves. When the macro is undefined, retries are
// unlimited and locked_out is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   load_req     in   one-cycle pulse that starts a frame (IDLE only)
//   s_bit        in   serial key bit
//   s_valid      in   s_bit is valid
//   s_ready      out  bit is accepted this cycle when s_valid is also high
//   key_p        out  committed MUX-select key (NP bits)
//   key_x        out  committed XOR key (NX bits)
//   key_valid    out  committed key is usable
//   busy         out  frame in progress (LOAD or CHECK)
//   err_parity   out  sticky: last completed frame failed parity
//   err_timeout  out  sticky: last frame timed out between bits
//   locked_out   out  lockout active
// ---------------------------------------------------------------------------
module logic_key_loader #(
    parameter int NP       = 4,
    parameter int NX       = 16,
    parameter int TO_CYC   = 64    // idle cycles tolerated between bits, 2..255
`ifdef KEY_LOADER_LOCKOUT_EN
    ,
    parameter int MAX_FAIL = 3     // consecutive failed frames before lockout
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          s_bit,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [NP-1:0] key_p,
    output logic [NX-1:0] key_x,
    output logic          key_valid,
    output logic          busy,
    output logic          err_parity,
    output logic          err_timeout,
    output logic          locked_out
);

    localparam int N    = NP + NX + 1;
    localparam int CW   = $clog2(N + 1);
    localparam int TO_W = 8;

`ifdef KEY_LOADER_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_LOCKED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [NP-1:0]   key_p_q, key_p_d;
    logic [NX-1:0]   key_x_q, key_x_d;
    logic            key_valid_q, key_valid_d;
    logic            err_par_q, err_par_d;
    logic            err_to_q, err_to_d;

    logic            load_start;
    logic            accept;
    logic            timeout_hit;
    logic            parity_bad;

    assign load_start  = (state_q == S_IDLE) && load_req;
    assign accept      = (state_q == S_LOAD) && s_valid;
    // The idle cycle that would bring the counter to TO_CYC ends the frame.
    assign timeout_hit = (state_q == S_LOAD) && !s_valid &&
                         (to_q == TO_W'(TO_CYC - 1));
    // Even parity: XOR over every frame bit, parity bit included, must be 0.
    assign parity_bad  = ^shadow_q;

    // Shadow register: each bit only loads when the bit counter points at it,
    // and the whole register clears when a new frame starts.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_shadow
            assign shadow_d[gi] = load_start                      ? 1'b0  :
                                  (accept && cnt_q == CW'(gi))    ? s_bit :
                                                                    shadow_q[gi];
        end
    endgenerate

`ifdef KEY_LOADER_LOCKOUT_EN
    logic [FW-1:0] fail_q, fail_d;
    logic          fail_event;

    assign fail_event = timeout_hit || ((state_q == S_CHECK) && parity_bad);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        key_p_d     = key_p_q;
        key_x_d     = key_x_q;
        key_valid_d = key_valid_q;
        err_par_d   = err_par_q;
        err_to_d    = err_to_q;
`ifdef KEY_LOADER_LOCKOUT_EN
        fail_d      = fail_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            end

            S_LOAD: begin
                // load_req is deliberately not looked at here.
                if (s_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    to_d  = '0;
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_CHECK;
                    end
                end else if (timeout_hit) begin
                    // Abandon the frame; the committed key stays as it was.
                    state_d  = S_IDLE;
                    to_d     = '0;
                    err_to_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_CHECK: begin
                state_d = S_IDLE;
                if (!parity_bad) begin
                    key_p_d     = shadow_q[NP-1:0];
                    key_x_d     = shadow_q[NP+NX-1:NP];
                    key_valid_d = 1'b1;
                    err_par_d   = 1'b0;
                    err_to_d    = 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
                    fail_d      = '0;
`endif
                end else begin
                    key_p_d     = '0;
                    key_x_d     = '0;
                    key_valid_d = 1'b0;
                    err_par_d   = 1'b1;
                end
            end

`ifdef KEY_LOADER_LOCKOUT_EN
            S_LOCKED: begin
                state_d = S_LOCKED;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef KEY_LOADER_LOCKOUT_EN
        // Saturating count of consecutive failures; reaching the limit
        // overrides whatever state the frame logic picked above.
        if (fail_event) begin
            if (fail_q < FW'(MAX_FAIL)) begin
                fail_d = fail_q + FW'(1);
            end
            if (fail_d >= FW'(MAX_FAIL)) begin
                state_d     = S_LOCKED;
                key_p_d     = '0;
                key_x_d     = '0;
                key_valid_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            to_q        <= '0;
            shadow_q    <= '0;
            key_p_q     <= '0;
            key_x_q     <= '0;
            key_valid_q <= 1'b0;
            err_par_q   <= 1'b0;
            err_to_q    <= 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            shadow_q    <= shadow_d;
            key_p_q     <= key_p_d;
            key_x_q     <= key_x_d;
            key_valid_q <= key_valid_d;
            err_par_q   <= err_par_d;
            err_to_q    <= err_to_d;
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_q      <= fail_d;
`endif
        end
    end

    assign s_ready     = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign key_p       = key_p_q;
    assign key_x       = key_x_q;
    assign key_valid   = key_valid_q;
    assign err_parity  = err_par_q;
    assign err_timeout = err_to_q;

`ifdef KEY_LOADER_LOCKOUT_EN
    assign locked_out  = (state_q == S_LOCKED);
`else
    assign locked_out  = 1'b0;
`endif

endmodule

// File: tb/tb_logic_key_loader.sv
// ---------------------------------------------------------------------------
// tb_logic_key_loader
//
// Directed bench for logic_key_loader with the default parameters
// (NP=4, NX=16, TO_CYC=64). Frames are built from hand-picked p/X values;
// expected key, flag and handshake values are written out explicitly.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_logic_key_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        s_bit;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  key_p;
    logic [15:0] key_x;
    logic        key_valid;
    logic        busy;
    logic        err_parity;
    logic        err_timeout;
    logic        locked_out;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    logic_key_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .s_bit       (s_bit),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .key_p       (key_p),
        .key_x       (key_x),
        .key_valid   (key_valid),
        .busy        (busy),
        .err_parity  (err_parity),
        .err_timeout (err_timeout),
        .locked_out  (locked_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame layout: p in bits 3:0, X in bits 19:4, parity in bit 20.
    function automatic logic [20:0] mk_frame(input logic [3:0] p, input logic [15:0] x,
                                             input bit bad_par);
        logic par;
        par = (^x) ^ (^p) ^ bad_par;
        return {par, x, p};
    endfunction

    task automatic start_frame();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Streams the first nbits of f. With gaps set, a one-cycle s_valid=0
    // bubble (carrying a wrong bit value and a stray load_req) precedes every
    // bit after the first. Returns right after the last bit's edge.
    task automatic send_bits(input logic [20:0] f, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i > 0) begin
                s_valid  = 1'b0;
                s_bit    = ~f[i];
                load_req = (i == 5);
                tick();
                load_req = 1'b0;
            end
            s_valid = 1'b1;
            s_bit   = f[i];
            tick();
        end
        s_valid = 1'b0;
        s_bit   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key_p"},  32'(key_p),       32'h0);
        chk({tag, "_key_x"},  32'(key_x),       32'h0);
        chk({tag, "_kvalid"}, 32'(key_valid),   32'h0);
        chk({tag, "_busy"},   32'(busy),        32'h0);
        chk({tag, "_sready"}, 32'(s_ready),     32'h0);
        chk({tag, "_errpar"}, 32'(err_parity),  32'h0);
        chk({tag, "_errto"},  32'(err_timeout), 32'h0);
        chk({tag, "_lockout"},32'(locked_out),  32'h0);
    endtask

    initial begin
        logic [20:0] f;

        rst      = 1'b1;
        load_req = 1'b0;
        s_bit    = 1'b0;
        s_valid  = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic load: p=A, X=3C5A, parity 0, no gaps.
        f = mk_frame(4'hA, 16'h3C5A, 1'b0);
        chk("basic_parbit", 32'(f[20]), 32'h0);
        start_frame();
        chk("basic_busy_load", 32'(busy), 32'h1);
        chk("basic_sready_load", 32'(s_ready), 32'h1);
        send_bits(f, 21, 1'b0);
        // Edge 21: last bit accepted, still in CHECK, key not yet visible.
        chk("basic_kvalid_e21", 32'(key_valid), 32'h0);
        chk("basic_busy_check", 32'(busy), 32'h1);
        chk("basic_sready_check", 32'(s_ready), 32'h0);
        load_req = 1'b1;           // arrives during CHECK, must be dropped
        tick();
        load_req = 1'b0;
        chk("basic_key_p", 32'(key_p), 32'hA);
        chk("basic_key_x", 32'(key_x), 32'h3C5A);
        chk("basic_kvalid", 32'(key_valid), 32'h1);
        chk("basic_busy_after", 32'(busy), 32'h0);
        tick();
        chk("check_loadreq_dropped", 32'(busy), 32'h0);
        $display("frame basic: key_p=%h key_x=%h key_valid=%b", key_p, key_x, key_valid);

        // Timeout: 7 bits then silence; the 64th idle edge ends the frame.
        f = mk_frame(4'h5, 16'h1234, 1'b0);
        start_frame();
        send_bits(f, 7, 1'b0);
        repeat (63) tick();
        chk("to_busy_63", 32'(busy), 32'h1);
        chk("to_flag_63", 32'(err_timeout), 32'h0);
        tick();
        chk("to_busy_64", 32'(busy), 32'h0);
        chk("to_sready", 32'(s_ready), 32'h0);
        chk("to_flag", 32'(err_timeout), 32'h1);
        chk("to_key_p", 32'(key_p), 32'hA);
        chk("to_key_x", 32'(key_x), 32'h3C5A);
        chk("to_kvalid", 32'(key_valid), 32'h1);
        $display("frame timeout: err_timeout=%b key_valid=%b", err_timeout, key_valid);

        // Good key F/FFFF; clears the sticky timeout flag.
        f = mk_frame(4'hF, 16'hFFFF, 1'b0);
        start_frame();
        send_bits(f, 21, 1'b0);
        tick();
        chk("ff_key_p", 32'(key_p), 32'hF);
        chk("ff_key_x", 32'(key_x), 32'hFFFF);
        chk("ff_kvalid", 32'(key_valid), 32'h1);
        chk("ff_errto_cleared", 32'(err_timeout), 32'h0);
        $display("frame ffff: key_p=%h key_x=%h key_valid=%b", key_p, key_x, key_valid);

        // Parity fail: basic frame with parity bit flipped to 1.
        f = mk_frame(4'hA, 16'h3C5A, 1'b1);
        chk("pf_parbit", 32'(f[20]), 32'h1);
        start_frame();
        send_bits(f, 21, 1'b0);
        chk("pf_key_x_hold", 32'(key_x), 32'hFFFF);
        tick();
        chk("pf_errpar", 32'(err_parity), 32'h1);
        chk("pf_kvalid", 32'(key_valid), 32'h0);
        chk("pf_key_p", 32'(key_p), 32'h0);
        chk("pf_key_x", 32'(key_x), 32'h0);
        $display("frame parity_bad: err_parity=%b key_valid=%b", err_parity, key_valid);

        // Gapped stream of the basic frame, stray load_req in a gap.
        f = mk_frame(4'hA, 16'h3C5A, 1'b0);
        start_frame();
        send_bits(f, 21, 1'b1);
        tick();
        chk("gap_key_p", 32'(key_p), 32'hA);
        chk("gap_key_x", 32'(key_x), 32'h3C5A);
        chk("gap_kvalid", 32'(key_valid), 32'h1);
        chk("gap_errpar_cleared", 32'(err_parity), 32'h0);
        chk("gap_busy", 32'(busy), 32'h0);
        $display("frame gapped: key_p=%h key_x=%h key_valid=%b", key_p, key_x, key_valid);

        // Reset after 10 bits, then a full good frame p=1, X=0001.
        f = mk_frame(4'hC, 16'hBEEF, 1'b0);
        start_frame();
        send_bits(f, 10, 1'b0);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        f = mk_frame(4'h1, 16'h0001, 1'b0);
        start_frame();
        send_bits(f, 21, 1'b0);
        tick();
        chk("rst_key_p", 32'(key_p), 32'h1);
        chk("rst_key_x", 32'(key_x), 32'h0001);
        chk("rst_kvalid", 32'(key_valid), 32'h1);
        $display("frame after_reset: key_p=%h key_x=%h key_valid=%b", key_p, key_x, key_valid);

`ifdef KEY_LOADER_LOCKOUT_EN
        // Three bad-parity frames lock the unit; a good frame is then ignored.
        f = mk_frame(4'h6, 16'h0F0F, 1'b1);
        for (int k = 0; k < 3; k++) begin
            start_frame();
            send_bits(f, 21, 1'b0);
            tick();
            chk("lk_lockout_progress", 32'(locked_out), (k == 2) ? 32'h1 : 32'h0);
        end
        f = mk_frame(4'h3, 16'h00FF, 1'b0);
        start_frame();
        chk("lk_sready", 32'(s_ready), 32'h0);
        chk("lk_busy", 32'(busy), 32'h0);
        send_bits(f, 21, 1'b0);
        tick();
        chk("lk_kvalid", 32'(key_valid), 32'h0);
        chk("lk_key_x", 32'(key_x), 32'h0);
        chk("lk_still_locked", 32'(locked_out), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("lk_rst_unlock", 32'(locked_out), 32'h0);
        start_frame();
        send_bits(f, 21, 1'b0);
        tick();
        chk("lk_relo_key_p", 32'(key_p), 32'h3);
        chk("lk_relo_key_x", 32'(key_x), 32'h00FF);
        chk("lk_relo_kvalid", 32'(key_valid), 32'h1);
        $display("frame lockout: locked_out=%b key_x=%h", locked_out, key_x);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
